// File: rtl/challenge_pkg.sv
// challenge_pkg
// Shared definitions for the challenge host: default key/response widths,
// the host FSM state type, the default challenge key and a small helper
// for sizing counters.
package challenge_pkg;

   localparam int KEY_W_DEFAULT  = 32;
   localparam int RESP_W_DEFAULT = 256;

   localparam logic [31:0] DEFAULT_KEY = 32'h1337beef;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      LATCH,
      RECV
   } hostState_t;

   // Larger of two widths, used to size the shared bit counter.
   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/challenge_host_shreg.sv
// challenge_host_shreg
// Generic parallel-load / shift-right register. The serial input enters at
// the MSB and the contents move one place towards the LSB per shift, so the
// LSB is the next bit to leave and the MSB is the most recent bit to arrive.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset, clears the register
//   load_i     parallel load of loadVal_i (takes priority over shift_i)
//   loadVal_i  value captured on load
//   shift_i    shift right by one, ser_i entering at the MSB
//   ser_i      serial input bit
//   q_o        register contents
module challenge_host_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] loadVal_i,
   input  logic         shift_i,
   input  logic         ser_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   // Next-state selection: a load wins over a shift so a new value can be
   // captured even on a cycle where the owner would otherwise be shifting.
   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = loadVal_i;
      end else if (shift_i) begin
         q_d = {ser_i, q_q[W-1:1]};
      end
   end

   // Storage, cleared straight away when reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/challenge_host.sv
// challenge_host
// Host side of a serial challenge/response exchange. On an accepted start it
// shifts KEY_W key bits out on mosi (LSB first) with cs low, raises cs for a
// single latch cycle, drops cs again and shifts RESP_W response bits in from
// miso. The first bit received ends up in resp[0].
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset, aborts any transaction
//   start       transaction request, only looked at while idle
//   key         key to send, captured on the accepting edge
//   busy        high whenever a transaction is in progress
//   done        one-cycle pulse when the response is complete
//   resp_valid  high from done until the next start is accepted
//   resp        received response
//   cs          chip-select / latch strobe to the responder
//   mosi        serial key bit to the responder
//   miso        serial response bit from the responder
module challenge_host
   import challenge_pkg::*;
#(
   parameter int KEY_W  = KEY_W_DEFAULT,
   parameter int RESP_W = RESP_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [KEY_W-1:0]  key,
   output logic              busy,
   output logic              done,
   output logic              resp_valid,
   output logic [RESP_W-1:0] resp,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);

   localparam int CNT_W = $clog2(maxInt(KEY_W, RESP_W)) + 1;
   localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);
   localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_W - 1);

   hostState_t        state_q;
   logic [CNT_W-1:0]  count_q;
   logic              cs_q;
   logic              done_q;
   logic              respValid_q;

   logic              keyLoad;
   logic              keyShift;
   logic              respShift;
   logic [KEY_W-1:0]  keyBits;
   logic [RESP_W-1:0] respBits;
   logic              unusedKeyBits;

   // The key register is loaded on the accepting edge and shifted once per
   // SEND edge. Zeros shift in behind the key, so after the last key bit has
   // gone out the register is empty and its LSB serves directly as the
   // registered mosi, which is therefore zero everywhere outside SEND.
   assign keyLoad   = (state_q == IDLE) && start;
   assign keyShift  = (state_q == SEND);
   assign respShift = (state_q == RECV);

   challenge_host_shreg #(
      .W (KEY_W)
   ) keyReg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (keyLoad),
      .loadVal_i (key),
      .shift_i   (keyShift),
      .ser_i     (1'b0),
      .q_o       (keyBits)
   );

   // The response register only ever shifts; it keeps its last contents
   // through IDLE until the first sample of the next transaction.
   challenge_host_shreg #(
      .W (RESP_W)
   ) respReg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (1'b0),
      .loadVal_i ('0),
      .shift_i   (respShift),
      .ser_i     (miso),
      .q_o       (respBits)
   );

   // Only the LSB of the key register is an output; the upper bits exist
   // purely to feed the shift chain.
   assign unusedKeyBits = ^keyBits[KEY_W-1:1];

   // Transaction sequencer. count_q tracks key bits sent during SEND and
   // response bits sampled during RECV; both phases restart it from zero.
   // done_q defaults low so it is a single-cycle pulse, and a start seen in
   // the done cycle is accepted because the state is already IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         cs_q        <= 1'b1;
         done_q      <= 1'b0;
         respValid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= SEND;
                  count_q     <= '0;
                  cs_q        <= 1'b0;
                  respValid_q <= 1'b0;
               end
            end
            SEND: begin
               if (count_q == KEY_LAST) begin
                  state_q <= LATCH;
                  cs_q    <= 1'b1;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            LATCH: begin
               state_q <= RECV;
               count_q <= '0;
               cs_q    <= 1'b0;
            end
            RECV: begin
               if (count_q == RESP_LAST) begin
                  state_q     <= IDLE;
                  cs_q        <= 1'b1;
                  done_q      <= 1'b1;
                  respValid_q <= 1'b1;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cs_q    <= 1'b1;
            end
         endcase
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign resp_valid = respValid_q;
   assign resp       = respBits;
   assign cs         = cs_q;
   assign mosi       = keyBits[0];

endmodule

// File: tb/tb_challenge_host.sv
// tb_challenge_host
// Self-checking bench for challenge_host. A behavioural model tracks how many
// edges have passed since the accepting edge and derives every output from
// that position; a compare process checks the DUT against it once per cycle.
// Directed scenarios add literal expectations, then a randomized loop runs.
module tb_challenge_host;

   localparam int KEY_W     = 32;
   localparam int RESP_W    = 256;
   localparam int LAST_EDGE = KEY_W + RESP_W + 1;
   localparam logic [RESP_W-1:0] PAT_P = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                          64'hdeadbeefcafef00d, 64'h5a5aa5a5c3c33c3c};

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [KEY_W-1:0]  key;
   logic              busy;
   logic              done;
   logic              resp_valid;
   logic [RESP_W-1:0] resp;
   logic              cs;
   logic              mosi;
   logic              miso = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [RESP_W-1:0] respPattern = '0;

   int                mK     = -1;
   logic [KEY_W-1:0]  mKey   = '0;
   logic [RESP_W-1:0] mColl  = '0;
   logic [RESP_W-1:0] mResp  = '0;
   logic              mDone  = 1'b0;
   logic              mValid = 1'b0;

   challenge_host #(
      .KEY_W  (KEY_W),
      .RESP_W (RESP_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key        (key),
      .busy       (busy),
      .done       (done),
      .resp_valid (resp_valid),
      .resp       (resp),
      .cs         (cs),
      .mosi       (mosi),
      .miso       (miso)
   );

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [RESP_W-1:0] actual,
                              input logic [RESP_W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
      end
   endtask

   // Model: mK is the number of edges since the accepting edge (-1 when idle).
   // Response bit i is sampled at edge KEY_W+2+i.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mK     = -1;
         mResp  = '0;
         mDone  = 1'b0;
         mValid = 1'b0;
      end else begin
         mDone = 1'b0;
         if (mK >= 0) begin
            mK++;
            if (mK >= KEY_W + 2) mColl[mK-KEY_W-2] = miso;
            if (mK == LAST_EDGE) begin
               mK     = -1;
               mDone  = 1'b1;
               mValid = 1'b1;
               mResp  = mColl;
            end
         end else if (start) begin
            mK     = 0;
            mKey   = key;
            mValid = 1'b0;
         end
      end
   end

   // Behavioural responder: presents the next pattern bit ahead of each
   // sampling edge, random noise at all other times.
   always @(negedge clk) begin
      if (mK >= KEY_W + 1 && mK <= KEY_W + RESP_W) miso = respPattern[mK-KEY_W-1];
      else miso = 1'($urandom);
   end

   // Per-cycle comparison against the model.
   always begin
      @(posedge clk);
      #1;
      checkOutput("cs", RESP_W'(cs), RESP_W'(mK == -1 || mK == KEY_W));
      checkOutput("mosi", RESP_W'(mosi), RESP_W'((mK >= 0 && mK < KEY_W) ? mKey[mK] : 1'b0));
      checkOutput("busy", RESP_W'(busy), RESP_W'(mK != -1));
      checkOutput("done", RESP_W'(done), RESP_W'(mDone));
      checkOutput("resp_valid", RESP_W'(resp_valid), RESP_W'(mValid));
      if (mK == -1 || mK < KEY_W + 2) checkOutput("resp", resp, mResp);
   end

   task automatic applyStimulus(input logic [KEY_W-1:0] k, input logic [RESP_W-1:0] pat);
      @(negedge clk);
      key         = k;
      respPattern = pat;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      key   = $urandom;
   endtask

   task automatic waitDone(input int e0, output int doneEdge);
      doneEdge = -1;
      for (int e = e0 + 1; e <= e0 + 400; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            doneEdge = e;
            break;
         end
      end
   endtask

   task automatic sendAndCapture(input logic [KEY_W-1:0] k, input logic [RESP_W-1:0] pat,
                                 output logic [KEY_W-1:0] got, output int csLow,
                                 output int doneEdge);
      applyStimulus(k, pat);
      csLow = 0;
      got   = '0;
      for (int i = 0; i < KEY_W; i++) begin
         got[i] = mosi;
         if (!cs) csLow++;
         @(negedge clk);
      end
      checkOutput("cs_latch_high", RESP_W'(cs), RESP_W'(1'b1));
      @(negedge clk);
      checkOutput("cs_recv_low", RESP_W'(cs), RESP_W'(1'b0));
      waitDone(KEY_W + 1, doneEdge);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached, actual running, required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [KEY_W-1:0]  got;
      logic [RESP_W-1:0] alt;
      int                csLow;
      int                doneEdge;
      int                prevEdge;
      int                budget;

      start = 1'b0;
      key   = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_cs", RESP_W'(cs), RESP_W'(1'b1));
      checkOutput("rst_mosi", RESP_W'(mosi), RESP_W'(1'b0));
      checkOutput("rst_busy", RESP_W'(busy), RESP_W'(1'b0));
      checkOutput("rst_done", RESP_W'(done), RESP_W'(1'b0));
      checkOutput("rst_valid", RESP_W'(resp_valid), RESP_W'(1'b0));
      checkOutput("rst_resp", resp, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] default key with fixed pattern");
      sendAndCapture(32'h1337beef, PAT_P, got, csLow, doneEdge);
      checkOutput("mosi_first8", RESP_W'(got[7:0]), RESP_W'(8'hEF));
      checkOutput("mosi_key", RESP_W'(got), RESP_W'(32'h1337beef));
      checkOutput("cs_low_send", RESP_W'(csLow), RESP_W'(32));
      checkOutput("done_edge", RESP_W'(doneEdge), RESP_W'(289));
      checkOutput("resp_pattern", resp, PAT_P);

      $display("[TB] all-zero and all-one keys");
      sendAndCapture(32'h00000000, ~PAT_P, got, csLow, doneEdge);
      checkOutput("mosi_zero", RESP_W'(got), RESP_W'(32'h00000000));
      checkOutput("cs_low_zero", RESP_W'(csLow), RESP_W'(32));
      checkOutput("resp_inv", resp, ~PAT_P);
      sendAndCapture(32'hFFFFFFFF, PAT_P, got, csLow, doneEdge);
      checkOutput("mosi_ones", RESP_W'(got), RESP_W'(32'hFFFFFFFF));
      checkOutput("cs_low_ones", RESP_W'(csLow), RESP_W'(32));
      checkOutput("done_edge_ones", RESP_W'(doneEdge), RESP_W'(289));

      $display("[TB] start held high, back-to-back");
      @(negedge clk);
      key         = 32'hA5A50F0F;
      respPattern = PAT_P;
      start       = 1'b1;
      prevEdge    = -1;
      for (int t = 0; t < 3; t++) begin
         waitDone(prevEdge, doneEdge);
         checkOutput("b2b_done_edge", RESP_W'(doneEdge), RESP_W'((t + 1) * 290 - 1));
         checkOutput("b2b_resp", resp, PAT_P);
         prevEdge = doneEdge;
      end
      @(negedge clk);
      start = 1'b0;

      $display("[TB] start and key change while busy");
      applyStimulus(32'hC0DE1234, ~PAT_P);
      repeat (99) @(negedge clk);
      start = 1'b1;
      key   = 32'h0BADF00D;
      @(negedge clk);
      start = 1'b0;
      waitDone(100, doneEdge);
      checkOutput("busy_ignore_edge", RESP_W'(doneEdge), RESP_W'(289));
      checkOutput("busy_ignore_resp", resp, ~PAT_P);

      $display("[TB] reset during receive");
      applyStimulus(32'h1337beef, PAT_P);
      repeat (149) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_cs", RESP_W'(cs), RESP_W'(1'b1));
      checkOutput("abort_busy", RESP_W'(busy), RESP_W'(1'b0));
      checkOutput("abort_resp", resp, '0);
      checkOutput("abort_valid", RESP_W'(resp_valid), RESP_W'(1'b0));
      checkOutput("abort_done", RESP_W'(done), RESP_W'(1'b0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sendAndCapture(32'h1337beef, PAT_P, got, csLow, doneEdge);
      checkOutput("after_abort_edge", RESP_W'(doneEdge), RESP_W'(289));
      checkOutput("after_abort_resp", resp, PAT_P);

      $display("[TB] alternating response bits");
      for (int i = 0; i < RESP_W; i++) alt[i] = (i % 2 == 0);
      sendAndCapture($urandom, alt, got, csLow, doneEdge);
      checkOutput("alt_resp", resp, {64{4'h5}});

      $display("[TB] randomized transactions");
      for (int n = 0; n < 6; n++) begin
         for (int w = 0; w < RESP_W / 32; w++) alt[w*32 +: 32] = $urandom;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus($urandom, alt);
         budget = 0;
         while (mK != -1 && budget < 400) begin
            start = (mK < LAST_EDGE - 1) ? 1'($urandom) : 1'b0;
            key   = $urandom;
            @(negedge clk);
            budget++;
         end
         start = 1'b0;
         checkOutput("rand_complete", RESP_W'(budget < 400), RESP_W'(1'b1));
         checkOutput("rand_resp", resp, alt);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
